// File: rtl/wb_la_subsystem.sv
// Wishbone slice: fixed-priority manager arbiter, address decoder, LA select register
// with a 128-bit LA source mux, and an error responder for unmapped addresses.
module wb_la_subsystem #(
  parameter int NUM_MANAGERS = 1,
  parameter int NUM_TEAMS    = 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [32*NUM_MANAGERS-1:0]    A_ADR_I,
  input  logic [32*NUM_MANAGERS-1:0]    A_DAT_I,
  input  logic [4*NUM_MANAGERS-1:0]     A_SEL_I,
  input  logic [NUM_MANAGERS-1:0]       A_WE_I,
  input  logic [NUM_MANAGERS-1:0]       A_STB_I,
  input  logic [NUM_MANAGERS-1:0]       A_CYC_I,
  output logic [32*NUM_MANAGERS-1:0]    A_DAT_O,
  output logic [NUM_MANAGERS-1:0]       A_ACK_O,
  input  logic                          wbs_ack_i_gpio,
  input  logic                          wbs_ack_i_sram,
  input  logic [31:0]                   wbs_dat_i_gpio,
  input  logic [31:0]                   wbs_dat_i_sram,
  output logic                          wbs_cyc_o_gpio,
  output logic                          wbs_stb_o_gpio,
  output logic                          wbs_we_o_gpio,
  output logic                          wbs_cyc_o_sram,
  output logic                          wbs_stb_o_sram,
  output logic                          wbs_we_o_sram,
  output logic [31:0]                   wbs_adr_o_gpio,
  output logic [31:0]                   wbs_dat_o_gpio,
  output logic [31:0]                   wbs_adr_o_sram,
  output logic [31:0]                   wbs_dat_o_sram,
  output logic [3:0]                    wbs_sel_o_gpio,
  output logic [3:0]                    wbs_sel_o_sram,
  input  logic [128*(NUM_TEAMS+1)-1:0]  designs_la_data_out_flat,
  output logic [127:0]                  la_data_out
);

  localparam int GW = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_e;

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  lowestReq;
  logic           grantCyc;

  logic        fCyc, fStb, fWe;
  logic [31:0] fAdr, fDat;
  logic [3:0]  fSel;

  logic        selLa, selGpio, selSram, selErr, req;
  logic        laAck_q, errAck_q;
  logic [31:0] laSel_q;
  logic        retAck;
  logic [31:0] retDat;

  // Lowest-index requester wins; the loop runs high-to-low so index 0 overrides.
  always_comb begin
    lowestReq = '0;
    grantCyc  = 1'b0;
    for (int m = NUM_MANAGERS - 1; m >= 0; m--) begin
      if (A_CYC_I[m]) lowestReq = GW'(m);
    end
    for (int m = 0; m < NUM_MANAGERS; m++) begin
      if (grant_q == GW'(m)) grantCyc = A_CYC_I[m];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (|A_CYC_I) begin
          state_d = ARB_GRANTED;
          grant_d = lowestReq;
        end
      end
      ARB_GRANTED: begin
        if (!grantCyc) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    fCyc = 1'b0;
    fStb = 1'b0;
    fWe  = 1'b0;
    fAdr = '0;
    fDat = '0;
    fSel = '0;
    if (state_q == ARB_GRANTED) begin
      for (int m = 0; m < NUM_MANAGERS; m++) begin
        if (grant_q == GW'(m)) begin
          fCyc = A_CYC_I[m];
          fStb = A_STB_I[m];
          fWe  = A_WE_I[m];
          fAdr = A_ADR_I[32*m +: 32];
          fDat = A_DAT_I[32*m +: 32];
          fSel = A_SEL_I[4*m +: 4];
        end
      end
    end
  end

  assign selLa   = (fAdr[31:16] == 16'h3100);
  assign selGpio = (fAdr[31:16] == 16'h3200);
  assign selSram = (fAdr[31:24] == 8'h33);
  assign selErr  = !(selLa || selGpio || selSram);
  assign req     = fCyc && fStb;

  assign wbs_cyc_o_gpio = fCyc && selGpio;
  assign wbs_stb_o_gpio = fStb && selGpio;
  assign wbs_we_o_gpio  = fWe  && selGpio;
  assign wbs_adr_o_gpio = selGpio ? fAdr : '0;
  assign wbs_dat_o_gpio = selGpio ? fDat : '0;
  assign wbs_sel_o_gpio = selGpio ? fSel : '0;
  assign wbs_cyc_o_sram = fCyc && selSram;
  assign wbs_stb_o_sram = fStb && selSram;
  assign wbs_we_o_sram  = fWe  && selSram;
  assign wbs_adr_o_sram = selSram ? fAdr : '0;
  assign wbs_dat_o_sram = selSram ? fDat : '0;
  assign wbs_sel_o_sram = selSram ? fSel : '0;

  // Acks are gated by their own previous value so a held strobe never gets back-to-back acks.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      laAck_q  <= 1'b0;
      errAck_q <= 1'b0;
      laSel_q  <= '0;
    end else begin
      laAck_q  <= req && selLa && !laAck_q;
      errAck_q <= req && selErr && !errAck_q;
      if (req && selLa && !laAck_q && fWe) begin
        for (int b = 0; b < 4; b++) begin
          if (fSel[b]) laSel_q[8*b +: 8] <= fDat[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    retAck = 1'b0;
    retDat = '0;
    if (fCyc) begin
      if (selLa) begin
        retAck = laAck_q;
        retDat = laSel_q;
      end else if (selGpio) begin
        retAck = wbs_ack_i_gpio;
        retDat = wbs_dat_i_gpio;
      end else if (selSram) begin
        retAck = wbs_ack_i_sram;
        retDat = wbs_dat_i_sram;
      end else begin
        retAck = errAck_q;
      end
    end
  end

  always_comb begin
    A_ACK_O = '0;
    A_DAT_O = '0;
    for (int m = 0; m < NUM_MANAGERS; m++) begin
      if (state_q == ARB_GRANTED && grant_q == GW'(m)) begin
        A_ACK_O[m]          = retAck;
        A_DAT_O[32*m +: 32] = retDat;
      end
    end
  end

  always_comb begin
    la_data_out = '0;
    for (int k = 0; k <= NUM_TEAMS; k++) begin
      if (laSel_q == 32'(k)) la_data_out = designs_la_data_out_flat[128*k +: 128];
    end
  end

endmodule

// File: tb/tb_wb_la_subsystem.sv
// Directed self-checking bench for wb_la_subsystem with two managers and one team design.
module tb_wb_la_subsystem;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [63:0]   aAdr, aDat;
  logic [7:0]    aSel;
  logic [1:0]    aWe, aStb, aCyc;
  logic [63:0]   aDatO;
  logic [1:0]    aAckO;
  logic          gpioAck, sramAck;
  logic [31:0]   gpioDat, sramDat;
  logic          gpioCyc, gpioStb, gpioWe, sramCyc, sramStb, sramWe;
  logic [31:0]   gpioAdr, gpioDatO, sramAdr, sramDatO;
  logic [3:0]    gpioSel, sramSel;
  logic [255:0]  laFlat;
  logic [127:0]  laOut;

  localparam logic [127:0] SRC0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] SRC1 = {16{8'hA5}};

  int checks = 0;
  int fails  = 0;
  logic [31:0] rdat;
  int cycles;

  always #5 CLK = ~CLK;

  assign gpioAck = gpioCyc && gpioStb;
  assign gpioDat = 32'h1234_5678;
  assign sramAck = sramCyc && sramStb;
  assign sramDat = 32'hCAFE_F00D;
  assign laFlat  = {SRC1, SRC0};

  wb_la_subsystem #(.NUM_MANAGERS(2), .NUM_TEAMS(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .A_ADR_I(aAdr), .A_DAT_I(aDat), .A_SEL_I(aSel),
    .A_WE_I(aWe), .A_STB_I(aStb), .A_CYC_I(aCyc),
    .A_DAT_O(aDatO), .A_ACK_O(aAckO),
    .wbs_ack_i_gpio(gpioAck), .wbs_ack_i_sram(sramAck),
    .wbs_dat_i_gpio(gpioDat), .wbs_dat_i_sram(sramDat),
    .wbs_cyc_o_gpio(gpioCyc), .wbs_stb_o_gpio(gpioStb), .wbs_we_o_gpio(gpioWe),
    .wbs_cyc_o_sram(sramCyc), .wbs_stb_o_sram(sramStb), .wbs_we_o_sram(sramWe),
    .wbs_adr_o_gpio(gpioAdr), .wbs_dat_o_gpio(gpioDatO),
    .wbs_adr_o_sram(sramAdr), .wbs_dat_o_sram(sramDatO),
    .wbs_sel_o_gpio(gpioSel), .wbs_sel_o_sram(sramSel),
    .designs_la_data_out_flat(laFlat),
    .la_data_out(laOut)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic driveMgr(input int mgr, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, input logic on);
    aAdr[mgr*32 +: 32] = adr;
    aDat[mgr*32 +: 32] = dat;
    aSel[mgr*4 +: 4]   = sel;
    aWe[mgr]           = we;
    aStb[mgr]          = on;
    aCyc[mgr]          = on;
  endtask

  // Called on a falling edge; returns read data and the number of cycles until ack.
  task automatic applyStimulus(input int mgr, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic we,
                               output logic [31:0] rd, output int cyc);
    bit acked = 1'b0;
    rd  = '0;
    cyc = 0;
    driveMgr(mgr, adr, dat, sel, we, 1'b1);
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge CLK);
      cyc++;
      if (aAckO[mgr]) begin
        acked = 1'b1;
        rd    = aDatO[mgr*32 +: 32];
      end
    end
    if (!acked) checkOutput("ack timeout", 128'd0, 128'd1);
    driveMgr(mgr, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nRST = 1'b0;
    aAdr = '0; aDat = '0; aSel = '0; aWe = '0; aStb = '0; aCyc = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset ack", 128'(aAckO), 128'd0);
    checkOutput("reset dat", 128'(aDatO), 128'd0);
    checkOutput("reset la_data_out", laOut, SRC0);
    checkOutput("reset slave cyc", 128'({gpioCyc, sramCyc, gpioStb, sramStb}), 128'd0);
    nRST = 1'b1;
    @(negedge CLK);

    applyStimulus(0, 32'h3100_0000, 32'h0000_000C, 4'hF, 1'b1, rdat, cycles);
    checkOutput("la write latency", 128'(cycles), 128'd2);
    applyStimulus(0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("la read latency", 128'(cycles), 128'd2);
    checkOutput("la read 0xC", 128'(rdat), 128'h0000_000C);
    checkOutput("la out sel 12", laOut, 128'd0);

    applyStimulus(0, 32'h3100_0000, 32'h1, 4'hF, 1'b1, rdat, cycles);
    checkOutput("la out sel 1", laOut, SRC1);
    applyStimulus(0, 32'h3100_0000, 32'h0, 4'hF, 1'b1, rdat, cycles);
    checkOutput("la out sel 0", laOut, SRC0);

    applyStimulus(0, 32'h3100_0000, 32'h0000_0100, 4'hF, 1'b1, rdat, cycles);
    applyStimulus(0, 32'h3100_0000, 32'hFFFF_FF03, 4'b0001, 1'b1, rdat, cycles);
    applyStimulus(0, 32'h3100_00FC, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("byte select read", 128'(rdat), 128'h0000_0103);

    driveMgr(0, 32'h3200_0004, 32'h0, 4'hF, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("gpio cyc/stb", 128'({gpioCyc, gpioStb}), 128'd3);
    checkOutput("gpio adr", 128'(gpioAdr), 128'h3200_0004);
    checkOutput("sram idle", 128'({sramCyc, sramStb, sramAdr}), 128'd0);
    checkOutput("gpio ack", 128'(aAckO), 128'd1);
    checkOutput("gpio read data", 128'(aDatO), 128'h0000_0000_1234_5678);
    driveMgr(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);

    applyStimulus(0, 32'h3300_0010, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("sram latency", 128'(cycles), 128'd1);
    checkOutput("sram read data", 128'(rdat), 128'hCAFE_F00D);

    applyStimulus(0, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, rdat, cycles);
    applyStimulus(0, 32'h4000_0000, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("unmapped latency", 128'(cycles), 128'd2);
    checkOutput("unmapped data", 128'(rdat), 128'd0);
    applyStimulus(0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("unmapped write dropped", 128'(rdat), 128'h0000_0103);

    driveMgr(0, 32'h3100_0000, 32'h5, 4'hF, 1'b1, 1'b1);
    driveMgr(1, 32'h3100_0000, 32'h7, 4'hF, 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("arb grant cycle", 128'(aAckO), 128'd0);
    @(negedge CLK);
    checkOutput("arb m0 first", 128'(aAckO), 128'd1);
    checkOutput("arb m1 dat zero", 128'(aDatO[63:32]), 128'd0);
    driveMgr(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("arb idle cycle", 128'(aAckO), 128'd0);
    @(negedge CLK);
    checkOutput("arb m1 grant cycle", 128'(aAckO), 128'd0);
    @(negedge CLK);
    checkOutput("arb m1 ack", 128'(aAckO), 128'd2);
    driveMgr(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("arb m1 wrote last", 128'(rdat), 128'h7);

    driveMgr(0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("held stb ack %0d", i), 128'(aAckO[0]), 128'(i % 2));
    end
    driveMgr(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);

    driveMgr(0, 32'h3100_0000, 32'h1, 4'hF, 1'b1, 1'b1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkOutput("reset mid ack", 128'(aAckO), 128'd0);
    checkOutput("reset mid la_data_out", laOut, SRC0);
    checkOutput("reset mid dat", 128'(aDatO), 128'd0);
    @(negedge CLK);
    driveMgr(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("reset held ack", 128'(aAckO), 128'd0);
    nRST = 1'b1;
    @(negedge CLK);
    applyStimulus(0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, rdat, cycles);
    checkOutput("la_sel after reset", 128'(rdat), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
